// File: rtl/div_if.sv
// Handshake bundle between EX and the iterative divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic               div_start;
    logic               div_signed;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               div_cancel;
    logic [2*WIDTH-1:0] div_result;
    logic               div_ready;
    logic               stallreq_for_ex;

    modport master (
        output div_start, div_signed, opdata1, opdata2, div_cancel,
        input  div_result, div_ready, stallreq_for_ex
    );

    modport slave (
        input  div_start, div_signed, opdata1, opdata2, div_cancel,
        output div_result, div_ready, stallreq_for_ex
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU in EX.
// Holds EX via stallreq_for_ex until {remainder, quotient} is ready.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH:0]     r_dvd;
    logic [WIDTH-1:0]     r_dvs;
    logic [WIDTH-1:0]     r_op1;
    logic                 r_signed;
    logic                 r_sign1;
    logic                 r_sign2;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_go;
    logic                 w_neg1;
    logic                 w_neg2;
    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic [2*WIDTH:0]     w_shift;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH:0]     w_step;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic                 w_last;

    assign w_go   = bus.div_start & ~bus.div_cancel;
    assign w_neg1 = bus.div_signed & bus.opdata1[WIDTH-1];
    assign w_neg2 = bus.div_signed & bus.opdata2[WIDTH-1];
    assign w_abs1 = w_neg1 ? -bus.opdata1 : bus.opdata1;
    assign w_abs2 = w_neg2 ? -bus.opdata2 : bus.opdata2;

    // Upper part is WIDTH+1 bits so the trial difference sign is its MSB
    assign w_shift = {r_dvd[2*WIDTH-1:0], 1'b0};
    assign w_diff  = w_shift[2*WIDTH:WIDTH] - {1'b0, r_dvs};
    assign w_step  = w_diff[WIDTH] ? w_shift
                                   : {w_diff, w_shift[WIDTH-1:1], 1'b1};

    assign w_quo = (r_signed & (r_sign1 ^ r_sign2)) ? -w_step[WIDTH-1:0]
                                                    : w_step[WIDTH-1:0];
    assign w_rem = (r_signed & r_sign1) ? -w_step[2*WIDTH-1:WIDTH]
                                        : w_step[2*WIDTH-1:WIDTH];
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FREE:   if (w_go) w_next = (bus.opdata2 == '0) ? S_BYZERO : S_ON;
            S_BYZERO: w_next = S_END;
            S_ON:     if (w_last) w_next = S_END;
            S_END:    w_next = S_FREE;
            default:  w_next = S_FREE;
        endcase
        if (bus.div_cancel) w_next = S_FREE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FREE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_op1    <= '0;
            r_signed <= 1'b0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_FREE: begin
                    if (w_go) begin
                        r_signed <= bus.div_signed;
                        r_sign1  <= bus.opdata1[WIDTH-1];
                        r_sign2  <= bus.opdata2[WIDTH-1];
                        r_op1    <= bus.opdata1;
                        r_dvs    <= w_abs2;
                        r_dvd    <= {{(WIDTH+1){1'b0}}, w_abs1};
                        r_cnt    <= '0;
                    end
                end
                S_ON: begin
                    r_dvd <= w_step;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last && !bus.div_cancel)
                        r_result <= {w_rem, w_quo};
                end
                S_BYZERO: begin
                    if (!bus.div_cancel)
                        r_result <= {r_op1, {WIDTH{1'b1}}};
                end
                default: ;
            endcase
        end
    end

    assign bus.div_result      = r_result;
    assign bus.div_ready       = (r_state == S_END);
    assign bus.stallreq_for_ex = w_go & (r_state != S_END);
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, sign rules, div-by-zero,
// cancel, reset and back-to-back issue, plus a short random sweep.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_div(input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int lat, input string tag);
        int   n;
        logic ok;
        @(posedge clk); #1;
        bus.div_start  = 1'b1;
        bus.div_signed = sg;
        bus.opdata1    = a;
        bus.opdata2    = b;
        n  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!bus.div_ready && n < 60) begin
            if (!bus.stallreq_for_ex) ok = 1'b0;
            n++;
            if (n == 2) begin
                bus.opdata1 = ~a;
                bus.opdata2 = b + 32'd1;
            end
            @(negedge clk);
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, bus.div_result, exp);
        chk({tag, "_stall_end"}, 64'(bus.stallreq_for_ex), 64'd0);
        chk({tag, "_stall_held"}, 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        @(negedge clk);
        chk({tag, "_rdy_pulse"}, 64'(bus.div_ready), 64'd0);
    endtask

    function automatic logic [63:0] model(input logic sg,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return {32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    initial begin
        int n;
        logic seen;
        logic sg;
        logic [31:0] a, b;

        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.div_cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_result", bus.div_result, 64'd0);
        chk("reset_ready", 64'(bus.div_ready), 64'd0);
        chk("reset_stall", 64'(bus.stallreq_for_ex), 64'd0);

        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "divu_100_7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE,
               {32'd1, 32'hFFFF_FFFD}, 33, "div_7_m2");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               {32'd0, 32'h8000_0000}, 33, "div_ovf");
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1,
               {32'd0, 32'hFFFF_FFFF}, 33, "divu_max_1");
        do_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               {32'd0, 32'd1}, 33, "divu_max_max");
        do_div(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD,
               {32'hFFFF_FFFE, 32'd2}, 33, "div_m8_m3");
        do_div(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 2, "divz_5_0");
        do_div(1'b1, 32'hFFFF_FFFA, 32'd0,
               {32'hFFFF_FFFA, 32'hFFFF_FFFF}, 2, "divz_m6_0");

        // Cancel at t+10
        @(posedge clk); #1;
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.opdata1    = 32'd100;
        bus.opdata2    = 32'd7;
        seen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.stallreq_for_ex) seen = 1'b0;
        end
        chk("cancel_pre_stall", 64'(seen), 64'd1);
        @(posedge clk); #1;
        bus.div_cancel = 1'b1;
        @(negedge clk);
        chk("cancel_stall", 64'(bus.stallreq_for_ex), 64'd0);
        @(posedge clk); #1;
        bus.div_cancel = 1'b0;
        bus.div_start  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.div_ready) seen = 1'b1;
        end
        chk("cancel_no_ready", 64'(seen), 64'd0);
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "after_cancel");

        // Reset at t+5
        @(posedge clk); #1;
        bus.div_start = 1'b1;
        bus.opdata1   = 32'd100;
        bus.opdata2   = 32'd7;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.div_start = 1'b0;
        @(negedge clk);
        chk("rst_result", bus.div_result, 64'd0);
        chk("rst_ready", 64'(bus.div_ready), 64'd0);
        chk("rst_stall", 64'(bus.stallreq_for_ex), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.div_ready) seen = 1'b1;
        end
        chk("rst_no_ready", 64'(seen), 64'd0);

        // Back-to-back 20/3 then 21/4
        @(posedge clk); #1;
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.opdata1    = 32'd20;
        bus.opdata2    = 32'd3;
        n = 0;
        @(negedge clk);
        while (!bus.div_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_first_lat", 64'(n), 64'd33);
        chk("b2b_first_res", bus.div_result, {32'd2, 32'd6});
        @(posedge clk); #1;
        bus.opdata1 = 32'd21;
        bus.opdata2 = 32'd4;
        n = 0;
        @(negedge clk);
        n = 1;
        while (!bus.div_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_gap", 64'(n), 64'd34);
        chk("b2b_second_res", bus.div_result, {32'd1, 32'd5});
        @(posedge clk); #1;
        bus.div_start = 1'b0;

        // Random sweep against the arithmetic model
        for (int i = 0; i < 100; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 1) b = 32'($urandom_range(0, 15));
            if (i % 4 == 2) b = b | 32'h8000_0000;
            do_div(sg, a, b, model(sg, a, b), (b == 32'd0) ? 2 : 33, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
